// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer.
// Frame-length helper is used by the RTL and the bench.
package piso_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int frame_len(
    input int width,
    input bit parity_en
  );
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Load/shift register and bit counter for the PISO serializer.
// head_d is the bit that will be on the line after this edge.
module piso_shift_core
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             adv,
  input  logic [WIDTH-1:0] data,
  output logic             head_d,
  output logic             last
);

  localparam int CNT_W = $clog2(frame_len(WIDTH, PARITY_EN));

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  // Next register/counter: load wins, else shift zeros in.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load) begin
      sreg_d = data;
      cnt_d  = '0;
    end else if (adv) begin
      sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                         : {1'b0, sreg_q[WIDTH-1:1]};
      cnt_d  = last ? '0 : cnt_q + 1'b1;
    end
  end

  assign head_d = MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0];

  // Register the shift state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// PISO transmitter: valid/ready load, one bit per clk out.
// Define PISO_PARITY_EN to append an even-parity bit per frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             busy
);

  state_t state_q, state_d;
  logic   ser_out_q, ser_out_d;
  logic   ser_valid_q, ser_valid_d;
  logic   ser_first_q, ser_first_d;
  logic   busy_q, busy_d;
  logic   head_d;
  logic   last;
  logic   last_slot;
  logic   accept;
  logic   adv;

`ifdef PISO_PARITY_EN
  logic par_q, par_d;
  assign last_slot = (state_q == PARITY);
`else
  assign last_slot = (state_q == SHIFT) && last;
`endif

  assign load_ready = reset && ((state_q == IDLE) || last_slot);
  assign accept     = load_valid && load_ready;
  assign adv        = (state_q == SHIFT) && !accept;

  piso_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .adv    (adv),
    .data   (load_data),
    .head_d (head_d),
    .last   (last)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: if (last) begin
`ifdef PISO_PARITY_EN
        state_d = PARITY;
`else
        state_d = accept ? SHIFT : IDLE;
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: state_d = accept ? SHIFT : IDLE;
`endif
      default: state_d = IDLE;
    endcase

    ser_valid_d = (state_d != IDLE);
    busy_d      = (state_d != IDLE);
    ser_first_d = accept;
    ser_out_d   = 1'b0;
    if (state_d == SHIFT) ser_out_d = head_d;
`ifdef PISO_PARITY_EN
    if (state_d == PARITY) ser_out_d = par_q;
    par_d = accept ? ^load_data : par_q;
`endif
  end

  // FSM state with registered line outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      busy_q      <= busy_d;
`ifdef PISO_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_first = ser_first_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer, WIDTH=4.
// Instance a is MSB-first, instance b is LSB-first.
module tb_piso_serializer;
  import piso_pkg::*;

  logic       clk;
  logic       reset;
  logic       a_valid, a_ready, a_out, a_sv, a_sf, a_busy;
  logic [3:0] a_data;
  logic       b_valid, b_ready, b_out, b_sv, b_sf, b_busy;
  logic [3:0] b_data;
  logic [3:0] rx;
  int         n_vec;
  int         n_err;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .load_valid (a_valid),
    .load_ready (a_ready),
    .load_data  (a_data),
    .ser_out    (a_out),
    .ser_valid  (a_sv),
    .ser_first  (a_sf),
    .busy       (a_busy)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .load_valid (b_valid),
    .load_ready (b_ready),
    .load_data  (b_data),
    .ser_out    (b_out),
    .ser_valid  (b_sv),
    .ser_first  (b_sf),
    .busy       (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic so, input logic sv,
                     input logic sf, input logic rdy, input logic bsy);
    chk({tag, ".out"}, {7'd0, a_out}, {7'd0, so});
    chk({tag, ".valid"}, {7'd0, a_sv}, {7'd0, sv});
    chk({tag, ".first"}, {7'd0, a_sf}, {7'd0, sf});
    chk({tag, ".ready"}, {7'd0, a_ready}, {7'd0, rdy});
    chk({tag, ".busy"}, {7'd0, a_busy}, {7'd0, bsy});
  endtask

  initial begin
    bit e2 [4];
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b0;
    a_valid = 1'b0;
    a_data  = 4'h0;
    b_valid = 1'b0;
    b_data  = 4'h0;
    rx      = 4'h0;
    #12;
    cyc("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    cyc("idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef PISO_PARITY_EN
    a_valid = 1'b1;
    a_data  = 4'b1011;
    tick();
    a_valid = 1'b0;
    cyc("p1c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); tick();
    cyc("p1c2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("p1c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("p1c4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("p1c5", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    cyc("p1c6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    a_valid = 1'b1;
    a_data  = 4'b1001;
    tick();
    a_valid = 1'b0;
    cyc("p2c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); tick();
    cyc("p2c2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("p2c3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("p2c4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("p2c5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    cyc("p2c6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    // MSB-first single frame.
    a_valid = 1'b1;
    a_data  = 4'b1011;
    tick();
    a_valid = 1'b0;
    cyc("t1c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); tick();
    cyc("t1c2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("t1c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("t1c4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    cyc("t1c5", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // LSB-first into an LSB-first SIPO model.
    e2 = '{1'b1, 1'b1, 1'b0, 1'b1};
    b_valid = 1'b1;
    b_data  = 4'b1011;
    tick();
    b_valid = 1'b0;
    for (int i = 0; i < frame_len(4, 1'b0); i++) begin
      chk($sformatf("t2b%0d", i), {7'd0, b_out}, {7'd0, e2[i]});
      chk($sformatf("t2v%0d", i), {7'd0, b_sv}, 8'd1);
      rx = {b_out, rx[3:1]};
      tick();
    end
    chk("t2rx", {4'd0, rx}, 8'h0b);
    chk("t2end", {7'd0, b_sv}, 8'd0);

    // Back-to-back A then 5.
    a_valid = 1'b1;
    a_data  = 4'hA;
    tick();
    a_data  = 4'h5;
    cyc("t3c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); tick();
    cyc("t3c2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("t3c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("t3c4", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    a_valid = 1'b0;
    cyc("t3c5", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); tick();
    cyc("t3c6", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("t3c7", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("t3c8", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    cyc("t3c9", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Held valid during F frame, data toggled.
    a_valid = 1'b1;
    a_data  = 4'hF;
    tick();
    a_data  = 4'hC;
    cyc("t4c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); tick();
    a_data  = 4'h0;
    cyc("t4c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    a_data  = 4'h3;
    cyc("t4c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("t4c4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    a_valid = 1'b0;
    a_data  = 4'hE;
    cyc("t4c5", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); tick();
    cyc("t4c6", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("t4c7", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("t4c8", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    cyc("t4c9", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Async reset in the middle of a C frame.
    a_valid = 1'b1;
    a_data  = 4'hC;
    tick();
    a_valid = 1'b0;
    cyc("t5c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); tick();
    cyc("t5c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    #2;
    reset = 1'b0;
    #1;
    cyc("t5rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    cyc("t5rel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    a_valid = 1'b1;
    a_data  = 4'h6;
    tick();
    a_valid = 1'b0;
    cyc("t6c1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); tick();
    cyc("t6c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("t6c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    cyc("t6c4", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    cyc("t6c5", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
